// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU round-robin sequencer:
//   - default operand/result/command widths
//   - ALU command encodings (all 16 codes)
//   - sequencer state encoding
//   - settle-counter width (SETTLE is limited to 1..15)
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int RES_W_DEF  = 16;
   localparam int CMD_W_DEF  = 4;
   localparam int CNT_W      = 4;

   typedef enum logic [3:0] {
      CMD_ADD  = 4'd0,
      CMD_INC  = 4'd1,
      CMD_SUB  = 4'd2,
      CMD_DEC  = 4'd3,
      CMD_MUL  = 4'd4,
      CMD_DIV  = 4'd5,
      CMD_SHR  = 4'd6,
      CMD_SHL  = 4'd7,
      CMD_AND  = 4'd8,
      CMD_OR   = 4'd9,
      CMD_INV  = 4'd10,
      CMD_NAND = 4'd11,
      CMD_NOR  = 4'd12,
      CMD_XOR  = 4'd13,
      CMD_XNOR = 4'd14,
      CMD_BUF  = 4'd15
   } alu_cmd_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } seq_state_e;

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//   Two-way round-robin arbiter. The pointer names the preferred requester;
//   if it is not requesting, the other requester wins. When advance is high
//   and something was granted, the pointer moves to the non-granted side so
//   contending requesters strictly alternate.
//
//   clk, rst_n : clock, asynchronous active-low reset (pointer -> 0)
//   req[1:0]   : request vector
//   advance    : the current grant was consumed this cycle
//   gnt[1:0]   : one-hot grant (all zero when nothing requests)
//   gnt_id     : index of the granted requester
// -----------------------------------------------------------------------------
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt,
   output logic       gnt_id
);

   logic ptr_q;
   logic ptr_d;
   logic other;

   assign other = ~ptr_q;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so
      // no path leaves it unassigned and no latch is inferred.
      gnt_id = ptr_q;
      ptr_d  = ptr_q;
      if (!req[ptr_q] && req[other]) begin
         gnt_id = other;
      end
      gnt = req & (gnt_id ? 2'b10 : 2'b01);
      if (advance && (gnt != 2'b00)) begin
         ptr_d = ~gnt_id;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples its input from before the edge, independent of order.
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/alu_rr_sequencer.sv
// -----------------------------------------------------------------------------
// alu_rr_sequencer
//   Shares one combinational ALU between two valid/ready requesters. A
//   round-robin arbiter picks a requester in IDLE; its operands and command
//   are latched onto the ALU inputs, held for SETTLE cycles (EXEC), then the
//   ALU result is registered and offered on the response channel (RESP)
//   until the consumer takes it.
//
//   clk, rst_n             : clock, asynchronous active-low reset
//   reqN_valid/ready       : requester N handshake (ready only in IDLE)
//   reqN_a/b/cmd           : requester N operands and ALU command
//   rsp_valid/ready        : response handshake
//   rsp_id/y/err           : issuing requester, result, DIV-by-zero flag
//   alu_a/b/cmd/oe, alu_y  : connection to the external ALU
//   busy                   : an operation is in flight
// -----------------------------------------------------------------------------
module alu_rr_sequencer
   import alu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int RES_W  = RES_W_DEF,
   parameter int CMD_W  = CMD_W_DEF,
   parameter int SETTLE = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [CMD_W-1:0]  req0_cmd,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [CMD_W-1:0]  req1_cmd,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [RES_W-1:0]  rsp_y,
   output logic              rsp_err,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [CMD_W-1:0]  alu_cmd,
   output logic              alu_oe,
   input  logic [RES_W-1:0]  alu_y,
   output logic              busy
);

   localparam logic [CNT_W-1:0] SETTLE_M1 = CNT_W'(SETTLE - 1);
   localparam logic [CMD_W-1:0] DIV_CODE  = CMD_W'(CMD_DIV);

   seq_state_e        state_q,     state_d;
   logic [DATA_W-1:0] alu_a_q,     alu_a_d;
   logic [DATA_W-1:0] alu_b_q,     alu_b_d;
   logic [CMD_W-1:0]  alu_cmd_q,   alu_cmd_d;
   logic              alu_oe_q,    alu_oe_d;
   logic              id_q,        id_d;
   logic [CNT_W-1:0]  cnt_q,       cnt_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [RES_W-1:0]  rsp_y_q,     rsp_y_d;
   logic              rsp_err_q,   rsp_err_d;
   logic              busy_q,      busy_d;

   logic [1:0] arb_req;
   logic [1:0] arb_gnt;
   logic       arb_gnt_id;
   logic       accept;
   logic       div_zero;

   assign arb_req = {req1_valid, req0_valid};

   rr_arb2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (arb_req),
      .advance (accept),
      .gnt     (arb_gnt),
      .gnt_id  (arb_gnt_id)
   );

   // The arbiter only grants a valid requester, so any grant in IDLE is an
   // accepted transfer. Readies are gated with rst_n so they read 0 while
   // reset is held, like every other output.
   assign accept     = (state_q == ST_IDLE) && (arb_gnt != 2'b00);
   assign req0_ready = rst_n && (state_q == ST_IDLE) && arb_gnt[0];
   assign req1_ready = rst_n && (state_q == ST_IDLE) && arb_gnt[1];

   assign div_zero = (alu_cmd_q == DIV_CODE) && (alu_b_q == '0);

   always_comb begin
      state_d     = state_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_cmd_d   = alu_cmd_q;
      alu_oe_d    = alu_oe_q;
      id_d        = id_q;
      cnt_d       = cnt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_y_d     = rsp_y_q;
      rsp_err_d   = rsp_err_q;

      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               alu_a_d   = arb_gnt_id ? req1_a   : req0_a;
               alu_b_d   = arb_gnt_id ? req1_b   : req0_b;
               alu_cmd_d = arb_gnt_id ? req1_cmd : req0_cmd;
               id_d      = arb_gnt_id;
               cnt_d     = SETTLE_M1;
               alu_oe_d  = 1'b1;
               state_d   = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (cnt_q == '0) begin
               // A divide by zero has no meaningful quotient; report the
               // error with a clean zero result instead of whatever the ALU
               // produced.
               rsp_err_d   = div_zero;
               rsp_y_d     = div_zero ? '0 : alu_y;
               rsp_valid_d = 1'b1;
               state_d     = ST_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               alu_oe_d    = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // NOTE: the datapath registers are reset along with control: a reset
   // mid-operation must drive every output to 0 at once and leave no stale
   // operand on the ALU.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_cmd_q   <= '0;
         alu_oe_q    <= 1'b0;
         id_q        <= 1'b0;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_y_q     <= '0;
         rsp_err_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_cmd_q   <= alu_cmd_d;
         alu_oe_q    <= alu_oe_d;
         id_q        <= id_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_y_q     <= rsp_y_d;
         rsp_err_q   <= rsp_err_d;
         busy_q      <= busy_d;
      end
   end

   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_cmd   = alu_cmd_q;
   assign alu_oe    = alu_oe_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = id_q;
   assign rsp_y     = rsp_y_q;
   assign rsp_err   = rsp_err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_rr_sequencer
//   Directed bench for alu_rr_sequencer. Instance u_dut uses SETTLE=1 for the
//   functional tests; instance u_dut4 uses SETTLE=4 for latency and the
//   mid-EXEC reset. A behavioural ALU drives alu_y for each instance.
// -----------------------------------------------------------------------------
module tb_alu_rr_sequencer;
   import alu_pkg::*;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   int   cyc;

   // Instance with SETTLE = 1
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [7:0]  req0_a, req0_b, req1_a, req1_b;
   logic [3:0]  req0_cmd, req1_cmd;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_err, alu_oe, busy;
   logic [15:0] rsp_y, alu_y;
   logic [7:0]  alu_a, alu_b;
   logic [3:0]  alu_cmd;

   // Instance with SETTLE = 4
   logic        d4_req0_valid, d4_req0_ready, d4_req1_valid, d4_req1_ready;
   logic [7:0]  d4_req0_a, d4_req0_b, d4_req1_a, d4_req1_b;
   logic [3:0]  d4_req0_cmd, d4_req1_cmd;
   logic        d4_rsp_valid, d4_rsp_ready, d4_rsp_id, d4_rsp_err, d4_alu_oe, d4_busy;
   logic [15:0] d4_rsp_y, d4_alu_y;
   logic [7:0]  d4_alu_a, d4_alu_b;
   logic [3:0]  d4_alu_cmd;

   function automatic logic [15:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [3:0] cmd, input logic oe);
      logic [15:0] ea, eb, r;
      ea = {8'h00, a};
      eb = {8'h00, b};
      case (cmd)
         4'd0:    r = ea + eb;
         4'd1:    r = ea + 16'd1;
         4'd2:    r = ea - eb;
         4'd3:    r = ea - 16'd1;
         4'd4:    r = ea * eb;
         4'd5:    r = (b == 8'h00) ? 16'hFFFF : ea / eb;
         4'd6:    r = ea >> 1;
         4'd7:    r = ea << 1;
         4'd8:    r = ea & eb;
         4'd9:    r = ea | eb;
         4'd10:   r = {8'h00, ~a};
         4'd11:   r = {8'h00, ~(a & b)};
         4'd12:   r = {8'h00, ~(a | b)};
         4'd13:   r = ea ^ eb;
         4'd14:   r = {8'h00, ~(a ^ b)};
         default: r = ea;
      endcase
      return oe ? r : 16'h0000;
   endfunction

   assign alu_y    = alu_model(alu_a, alu_b, alu_cmd, alu_oe);
   assign d4_alu_y = alu_model(d4_alu_a, d4_alu_b, d4_alu_cmd, d4_alu_oe);

   alu_rr_sequencer #(.DATA_W(8), .RES_W(16), .CMD_W(4), .SETTLE(1)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_cmd   (req0_cmd),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_cmd   (req1_cmd),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_y      (rsp_y),
      .rsp_err    (rsp_err),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_cmd    (alu_cmd),
      .alu_oe     (alu_oe),
      .alu_y      (alu_y),
      .busy       (busy)
   );

   alu_rr_sequencer #(.DATA_W(8), .RES_W(16), .CMD_W(4), .SETTLE(4)) u_dut4 (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (d4_req0_valid),
      .req0_ready (d4_req0_ready),
      .req0_a     (d4_req0_a),
      .req0_b     (d4_req0_b),
      .req0_cmd   (d4_req0_cmd),
      .req1_valid (d4_req1_valid),
      .req1_ready (d4_req1_ready),
      .req1_a     (d4_req1_a),
      .req1_b     (d4_req1_b),
      .req1_cmd   (d4_req1_cmd),
      .rsp_valid  (d4_rsp_valid),
      .rsp_ready  (d4_rsp_ready),
      .rsp_id     (d4_rsp_id),
      .rsp_y      (d4_rsp_y),
      .rsp_err    (d4_rsp_err),
      .alu_a      (d4_alu_a),
      .alu_b      (d4_alu_b),
      .alu_cmd    (d4_alu_cmd),
      .alu_oe     (d4_alu_oe),
      .alu_y      (d4_alu_y),
      .busy       (d4_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; all sampling and driving happens 1 time unit after
   // the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present an operation on one requester of u_dut and hold it until the
   // accepting edge, then withdraw it.
   task automatic issue(input logic id, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] cmd);
      int n;
      n = 0;
      if (id) begin
         req1_a = a; req1_b = b; req1_cmd = cmd; req1_valid = 1'b1;
      end else begin
         req0_a = a; req0_b = b; req0_cmd = cmd; req0_valid = 1'b1;
      end
      #1;
      while (!(id ? req1_ready : req0_ready) && n < 20) begin
         step();
         n++;
      end
      check("issue_ready", {31'd0, (id ? req1_ready : req0_ready)}, 32'd1);
      step();
      if (id) req1_valid = 1'b0;
      else    req0_valid = 1'b0;
   endtask

   // Wait (bounded) for a u_dut response, compare it, and let it be consumed.
   task automatic expect_rsp(input string tag, input logic id, input logic [15:0] y,
                             input logic err);
      int n;
      n = 0;
      while (!rsp_valid && n < 20) begin
         step();
         n++;
      end
      check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
      check({tag, "_id"},    {31'd0, rsp_id},    {31'd0, id});
      check({tag, "_y"},     {16'd0, rsp_y},     {16'd0, y});
      check({tag, "_err"},   {31'd0, rsp_err},   {31'd0, err});
      step();
   endtask

   initial begin
      int n;
      int last_grant;
      logic gid;
      logic seen;

      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      req0_valid = 0; req0_a = 0; req0_b = 0; req0_cmd = 0;
      req1_valid = 0; req1_a = 0; req1_b = 0; req1_cmd = 0;
      rsp_ready  = 1'b1;
      d4_req0_valid = 0; d4_req0_a = 0; d4_req0_b = 0; d4_req0_cmd = 0;
      d4_req1_valid = 0; d4_req1_a = 0; d4_req1_b = 0; d4_req1_cmd = 0;
      d4_rsp_ready  = 1'b1;

      // ---- reset values ----
      step();
      step();
      check("rst_busy",      {31'd0, busy},      32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_alu_oe",    {31'd0, alu_oe},    32'd0);
      check("rst_alu_a",     {24'd0, alu_a},     32'd0);
      check("rst_rsp_y",     {16'd0, rsp_y},     32'd0);
      check("rst_req0_ready",{31'd0, req0_ready},32'd0);
      rst_n = 1'b1;
      step();

      // ---- single op: ADD 20+10, latency SETTLE+1 = 2 ----
      req0_a = 8'd20; req0_b = 8'd10; req0_cmd = 4'd0; req0_valid = 1'b1;
      #1;
      check("single_ready0", {31'd0, req0_ready}, 32'd1);
      check("single_ready1", {31'd0, req1_ready}, 32'd0);
      step();
      req0_valid = 1'b0;
      check("single_exec_valid", {31'd0, rsp_valid}, 32'd0);
      check("single_exec_busy",  {31'd0, busy},      32'd1);
      check("single_exec_oe",    {31'd0, alu_oe},    32'd1);
      check("single_exec_a",     {24'd0, alu_a},     32'd20);
      check("single_exec_b",     {24'd0, alu_b},     32'd10);
      step();
      check("single_valid", {31'd0, rsp_valid}, 32'd1);
      check("single_y",     {16'd0, rsp_y},     32'd30);
      check("single_id",    {31'd0, rsp_id},    32'd0);
      check("single_err",   {31'd0, rsp_err},   32'd0);
      step();
      check("single_done_valid", {31'd0, rsp_valid}, 32'd0);
      check("single_done_busy",  {31'd0, busy},      32'd0);
      check("single_done_oe",    {31'd0, alu_oe},    32'd0);
      check("single_hold_a",     {24'd0, alu_a},     32'd20);

      // ---- product width: MUL FF*FF on requester 1 ----
      issue(1'b1, 8'hFF, 8'hFF, 4'd4);
      expect_rsp("mul", 1'b1, 16'hFE01, 1'b0);

      // ---- contention: both valid, SUB 50-8 on 0, XOR F0^3C on 1 ----
      req0_a = 8'd50;  req0_b = 8'd8;   req0_cmd = 4'd2;  req0_valid = 1'b1;
      req1_a = 8'hF0;  req1_b = 8'h3C;  req1_cmd = 4'd13; req1_valid = 1'b1;
      #1;
      last_grant = 0;
      for (int i = 0; i < 4; i++) begin
         n = 0;
         while (!(req0_ready || req1_ready) && n < 20) begin
            step();
            n++;
         end
         check("cont_one_hot", {30'd0, req1_ready, req0_ready},
               (i % 2 == 0) ? 32'd1 : 32'd2);
         if (i > 0) check("cont_spacing", cyc - last_grant, 32'd3);
         last_grant = cyc;
         gid = req1_ready;
         step();
         n = 0;
         while (!rsp_valid && n < 20) begin
            step();
            n++;
         end
         check("cont_rsp_id", {31'd0, rsp_id}, (i % 2 == 0) ? 32'd0 : 32'd1);
         check("cont_rsp_y",  {16'd0, rsp_y},  gid ? 32'h00CC : 32'd42);
         step();
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;

      // ---- divide by zero, then a legal divide ----
      issue(1'b0, 8'd25, 8'd0, 4'd5);
      expect_rsp("div0", 1'b0, 16'h0000, 1'b1);
      issue(1'b0, 8'd25, 8'd5, 4'd5);
      expect_rsp("div5", 1'b0, 16'd5, 1'b0);

      // ---- backpressure: AND 12&34 on requester 1, rsp_ready low 5 cycles ----
      rsp_ready = 1'b0;
      issue(1'b1, 8'h12, 8'h34, 4'd8);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      n = 0;
      while (!rsp_valid && n < 20) begin
         step();
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         check("bp_valid",  {31'd0, rsp_valid},  32'd1);
         check("bp_y",      {16'd0, rsp_y},      32'h0010);
         check("bp_id",     {31'd0, rsp_id},     32'd1);
         check("bp_ready0", {31'd0, req0_ready}, 32'd0);
         check("bp_ready1", {31'd0, req1_ready}, 32'd0);
         check("bp_busy",   {31'd0, busy},       32'd1);
         step();
      end
      rsp_ready  = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      step();
      check("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
      check("bp_release_busy",  {31'd0, busy},      32'd0);

      // ---- SETTLE=4: latency of ADD 3+4 is SETTLE+1 = 5 edges ----
      d4_req0_a = 8'd3; d4_req0_b = 8'd4; d4_req0_cmd = 4'd0; d4_req0_valid = 1'b1;
      #1;
      check("s4_ready0", {31'd0, d4_req0_ready}, 32'd1);
      step();
      d4_req0_valid = 1'b0;
      n = 1;
      while (!d4_rsp_valid && n < 20) begin
         step();
         n++;
      end
      check("s4_latency", n, 32'd5);
      check("s4_y",       {16'd0, d4_rsp_y}, 32'd7);
      step();

      // ---- SETTLE=4: reset mid-EXEC ----
      d4_req0_a = 8'd9; d4_req0_b = 8'd2; d4_req0_cmd = 4'd2; d4_req0_valid = 1'b1;
      #1;
      step();
      d4_req0_valid = 1'b0;
      step();
      check("s4_mid_busy", {31'd0, d4_busy}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_busy",   {31'd0, d4_busy},      32'd0);
      check("rst_mid_oe",     {31'd0, d4_alu_oe},    32'd0);
      check("rst_mid_a",      {24'd0, d4_alu_a},     32'd0);
      check("rst_mid_cmd",    {28'd0, d4_alu_cmd},   32'd0);
      check("rst_mid_valid",  {31'd0, d4_rsp_valid}, 32'd0);
      #3;
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (d4_rsp_valid) seen = 1'b1;
      end
      check("rst_no_response", {31'd0, seen}, 32'd0);

      // Both valid after reset: pointer is back at requester 0.
      d4_req0_a = 8'h5A; d4_req0_cmd = 4'd15; d4_req0_valid = 1'b1;
      d4_req1_a = 8'h0F; d4_req1_cmd = 4'd10; d4_req1_valid = 1'b1;
      #1;
      check("rst_next_ready0", {31'd0, d4_req0_ready}, 32'd1);
      check("rst_next_ready1", {31'd0, d4_req1_ready}, 32'd0);
      step();
      d4_req0_valid = 1'b0;
      d4_req1_valid = 1'b0;
      n = 0;
      while (!d4_rsp_valid && n < 20) begin
         step();
         n++;
      end
      check("rst_next_id", {31'd0, d4_rsp_id}, 32'd0);
      check("rst_next_y",  {16'd0, d4_rsp_y},  32'h005A);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
